// File: rtl/rgmii_sfd_detector.sv
// RGMII receive front end: registers the de-DDR'd nibble pair, hunts for the
// 0x55 preamble and 0xD5 SFD, then frames the payload bytes with SOF/EOF/error
// markers. A one-deep holding register delays each payload byte by one cycle
// so that the last byte of a frame can be tagged with EOF when dv drops.
module rgmii_sfd_detector #(
    parameter int unsigned MIN_PREAMBLE = 2,
    parameter int unsigned MAX_PREAMBLE = 15
) (
    input  logic        rx_clk,
    input  logic        rst_n,
    input  logic [3:0]  rxd_rise,
    input  logic [3:0]  rxd_fall,
    input  logic        rx_dv,
    input  logic        rx_er_x,
    output logic        sfd_hit,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [15:0] sfd_count,
    output logic [15:0] bad_pre_count
);

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [3:0] PRE_MIN  = 4'(MIN_PREAMBLE);
    localparam logic [3:0] PRE_MAX  = 4'(MAX_PREAMBLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_FRAME,
        S_DROP
    } state_t;

    // Preamble counter: holds once it reaches the ceiling.
    function automatic logic [3:0] sat_inc_pre(input logic [3:0] v);
        return (v >= PRE_MAX) ? v : v + 4'd1;
    endfunction

    // Rejected-preamble statistic: sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage 0 input register
    logic [7:0]  byte_q;
    logic        dv_q;
    logic        er_q;

    // FSM / holding register / output registers
    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        hold_first_q, hold_first_d;
    logic        err_flag_q, err_flag_d;
    logic        sfd_hit_q, sfd_hit_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_sof_q, rx_sof_d;
    logic        rx_eof_q, rx_eof_d;
    logic        rx_err_q, rx_err_d;
    logic [15:0] sfd_count_q, sfd_count_d;
    logic [15:0] bad_pre_count_q, bad_pre_count_d;
    logic        sfd_inc;
    logic        bad_inc;

    // Capture the nibble pair and recover the error bit from the RX_CTL pair.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= 8'h00;
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
        end else begin
            byte_q <= {rxd_fall, rxd_rise};
            dv_q   <= rx_dv;
            er_q   <= rx_dv ^ rx_er_x;
        end
    end

    // Next-state and registered-output logic for the preamble/frame FSM.
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        hold_first_d = hold_first_q;
        err_flag_d   = err_flag_q;
        sfd_hit_d    = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_sof_d     = 1'b0;
        rx_eof_d     = 1'b0;
        rx_err_d     = 1'b0;
        sfd_inc      = 1'b0;
        bad_inc      = 1'b0;

        case (state_q)
            S_IDLE: begin
                hold_full_d = 1'b0;
                // dv low with er high is false carrier / extension: ignored.
                if (dv_q) begin
                    if (byte_q == PRE_BYTE) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = S_DROP;
                        bad_inc = 1'b1;
                    end
                end
            end

            S_PRE: begin
                if (!dv_q) begin
                    state_d = S_IDLE;
                    bad_inc = 1'b1;
                end else if (byte_q == PRE_BYTE) begin
                    pre_cnt_d = sat_inc_pre(pre_cnt_q);
                end else if (byte_q == SFD_BYTE && pre_cnt_q >= PRE_MIN) begin
                    state_d     = S_FRAME;
                    sfd_hit_d   = 1'b1;
                    sfd_inc     = 1'b1;
                    err_flag_d  = 1'b0;
                    hold_full_d = 1'b0;
                end else begin
                    state_d = S_DROP;
                    bad_inc = 1'b1;
                end
            end

            S_FRAME: begin
                if (er_q) begin
                    err_flag_d = 1'b1;
                end
                if (dv_q) begin
                    // A new byte pushes the held one out; only the very first
                    // byte loaded into an empty register carries SOF.
                    if (hold_full_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = hold_q;
                        rx_sof_d   = hold_first_q;
                    end
                    hold_d       = byte_q;
                    hold_full_d  = 1'b1;
                    hold_first_d = !hold_full_q;
                end else begin
                    // End of frame: flush the held byte as the last one.
                    if (hold_full_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = hold_q;
                        rx_sof_d   = hold_first_q;
                        rx_eof_d   = 1'b1;
                        rx_err_d   = err_flag_q;
                    end
                    hold_full_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            S_DROP: begin
                if (!dv_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                hold_full_d = 1'b0;
            end
        endcase

        sfd_count_d     = sfd_count_q + {15'd0, sfd_inc};
        bad_pre_count_d = bad_inc ? sat_inc16(bad_pre_count_q) : bad_pre_count_q;
    end

    // FSM state, holding register, outputs and statistics.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            pre_cnt_q       <= 4'd0;
            hold_q          <= 8'h00;
            hold_full_q     <= 1'b0;
            hold_first_q    <= 1'b0;
            err_flag_q      <= 1'b0;
            sfd_hit_q       <= 1'b0;
            rx_data_q       <= 8'h00;
            rx_valid_q      <= 1'b0;
            rx_sof_q        <= 1'b0;
            rx_eof_q        <= 1'b0;
            rx_err_q        <= 1'b0;
            sfd_count_q     <= 16'h0000;
            bad_pre_count_q <= 16'h0000;
        end else begin
            state_q         <= state_d;
            pre_cnt_q       <= pre_cnt_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            hold_first_q    <= hold_first_d;
            err_flag_q      <= err_flag_d;
            sfd_hit_q       <= sfd_hit_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            rx_sof_q        <= rx_sof_d;
            rx_eof_q        <= rx_eof_d;
            rx_err_q        <= rx_err_d;
            sfd_count_q     <= sfd_count_d;
            bad_pre_count_q <= bad_pre_count_d;
        end
    end

    assign sfd_hit       = sfd_hit_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_sof        = rx_sof_q;
    assign rx_eof        = rx_eof_q;
    assign rx_err        = rx_err_q;
    assign sfd_count     = sfd_count_q;
    assign bad_pre_count = bad_pre_count_q;

endmodule

// File: tb/tb_rgmii_sfd_detector.sv
// Bench for rgmii_sfd_detector. Stimulus is queued as per-cycle (dv, er, byte)
// triples; a burst-level reference model (each dv-high run is one attempt:
// count leading 0x55s, look for 0xD5, the rest is payload) predicts per-cycle
// outputs and the statistics counters. A second instance with MIN_PREAMBLE=1
// shares the inputs.
module tb_rgmii_sfd_detector;

    logic        rx_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rxd_rise, rxd_fall;
    logic        rx_dv, rx_er_x;
    logic        sfd_hit, rx_valid, rx_sof, rx_eof, rx_err;
    logic [7:0]  rx_data;
    logic [15:0] sfd_count, bad_pre_count;
    logic        sfd_hit1, rx_valid1, rx_sof1, rx_eof1, rx_err1;
    logic [7:0]  rx_data1;
    logic [15:0] sfd_count1, bad_pre_count1;

    always #4 rx_clk = ~rx_clk;

    rgmii_sfd_detector #(.MIN_PREAMBLE(2), .MAX_PREAMBLE(15)) dut (
        .rx_clk(rx_clk), .rst_n(rst_n), .rxd_rise(rxd_rise), .rxd_fall(rxd_fall),
        .rx_dv(rx_dv), .rx_er_x(rx_er_x), .sfd_hit(sfd_hit), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
        .sfd_count(sfd_count), .bad_pre_count(bad_pre_count)
    );

    rgmii_sfd_detector #(.MIN_PREAMBLE(1), .MAX_PREAMBLE(15)) dut1 (
        .rx_clk(rx_clk), .rst_n(rst_n), .rxd_rise(rxd_rise), .rxd_fall(rxd_fall),
        .rx_dv(rx_dv), .rx_er_x(rx_er_x), .sfd_hit(sfd_hit1), .rx_data(rx_data1),
        .rx_valid(rx_valid1), .rx_sof(rx_sof1), .rx_eof(rx_eof1), .rx_err(rx_err1),
        .sfd_count(sfd_count1), .bad_pre_count(bad_pre_count1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  q_by[$];
    bit          q_dv[$];
    bit          q_er[$];
    logic [15:0] m_sfd, m_bad, m_sfd1, m_bad1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_b(input bit dv, input logic [7:0] b, input bit er);
        q_dv.push_back(dv);
        q_by.push_back(b);
        q_er.push_back(er);
    endtask

    task automatic add_pre(input int n);
        for (int k = 0; k < n; k++) add_b(1'b1, 8'h55, 1'b0);
    endtask

    task automatic add_gap(input int n);
        for (int k = 0; k < n; k++) add_b(1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Predict, drive and check one queued segment, then clear the queues.
    task automatic run_seg(input string name);
        int L, i, s, e, n;
        bit ok, any_er;
        bit e_hit[], e_hit1[], e_vld[], e_sof[], e_eof[], e_err[];
        logic [7:0] e_dat[];
        add_gap(3);
        L = q_dv.size();
        e_hit = new[L]; e_hit1 = new[L]; e_vld = new[L];
        e_sof = new[L]; e_eof = new[L]; e_err = new[L]; e_dat = new[L];
        for (int k = 0; k < L; k++) e_dat[k] = 8'h00;
        i = 0;
        while (i < L) begin
            if (!q_dv[i]) begin
                i++;
            end else begin
                s = i;
                e = i;
                while (e + 1 < L && q_dv[e + 1]) e++;
                n = 0;
                while (s + n <= e && q_by[s + n] == 8'h55) n++;
                ok = (s + n <= e) && (q_by[s + n] == 8'hD5);
                if (ok && n >= 2) begin
                    m_sfd++;
                    e_hit[s + n + 1] = 1'b1;
                    any_er = 1'b0;
                    for (int j = s + n + 1; j <= e; j++) any_er |= q_er[j];
                    for (int j = s + n + 1; j <= e; j++) begin
                        e_vld[j + 2] = 1'b1;
                        e_dat[j + 2] = q_by[j];
                        e_sof[j + 2] = (j == s + n + 1);
                        e_eof[j + 2] = (j == e);
                        e_err[j + 2] = (j == e) && any_er;
                    end
                end else begin
                    m_bad = sat16(m_bad);
                end
                if (ok && n >= 1) begin
                    m_sfd1++;
                    e_hit1[s + n + 1] = 1'b1;
                end else begin
                    m_bad1 = sat16(m_bad1);
                end
                i = e + 1;
            end
        end
        for (int c = 0; c < L; c++) begin
            rxd_rise = q_by[c][3:0];
            rxd_fall = q_by[c][7:4];
            rx_dv    = q_dv[c];
            rx_er_x  = q_dv[c] ^ q_er[c];
            @(posedge rx_clk);
            #1;
            chk({name, ":sfd_hit"}, 32'(sfd_hit), 32'(e_hit[c]));
            chk({name, ":sfd_hit_min1"}, 32'(sfd_hit1), 32'(e_hit1[c]));
            chk({name, ":rx_valid"}, 32'(rx_valid), 32'(e_vld[c]));
            if (e_vld[c]) begin
                chk({name, ":rx_data"}, 32'(rx_data), 32'(e_dat[c]));
                chk({name, ":rx_sof"}, 32'(rx_sof), 32'(e_sof[c]));
                chk({name, ":rx_eof"}, 32'(rx_eof), 32'(e_eof[c]));
                chk({name, ":rx_err"}, 32'(rx_err), 32'(e_err[c]));
            end else begin
                chk({name, ":markers_idle"}, 32'({rx_sof, rx_eof, rx_err}), 32'd0);
            end
        end
        chk({name, ":sfd_count"}, 32'(sfd_count), 32'(m_sfd));
        chk({name, ":bad_pre_count"}, 32'(bad_pre_count), 32'(m_bad));
        chk({name, ":sfd_count_min1"}, 32'(sfd_count1), 32'(m_sfd1));
        chk({name, ":bad_pre_count_min1"}, 32'(bad_pre_count1), 32'(m_bad1));
        q_dv.delete();
        q_by.delete();
        q_er.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ":sfd_hit"}, 32'(sfd_hit), 32'd0);
        chk({name, ":rx_valid"}, 32'(rx_valid), 32'd0);
        chk({name, ":markers"}, 32'({rx_sof, rx_eof, rx_err}), 32'd0);
        chk({name, ":rx_data"}, 32'(rx_data), 32'd0);
        chk({name, ":sfd_count"}, 32'(sfd_count), 32'd0);
        chk({name, ":bad_pre_count"}, 32'(bad_pre_count), 32'd0);
        chk({name, ":min1_outs"}, 32'({sfd_hit1, rx_valid1, rx_sof1, rx_eof1, rx_err1}), 32'd0);
        chk({name, ":min1_counts"}, {sfd_count1, bad_pre_count1}, 32'd0);
    endtask

    initial begin
        int npre, npay, kind;
        rst_n = 1'b0;
        rxd_rise = 4'h0; rxd_fall = 4'h0; rx_dv = 1'b0; rx_er_x = 1'b0;
        m_sfd = 16'd0; m_bad = 16'd0; m_sfd1 = 16'd0; m_bad1 = 16'd0;
        repeat (3) @(posedge rx_clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Standard frame
        add_gap(2);
        add_pre(7); add_b(1, 8'hD5, 0);
        add_b(1, 8'h11, 0); add_b(1, 8'h22, 0); add_b(1, 8'h33, 0);
        run_seg("standard");
        chk("standard:sfd_count_const", 32'(sfd_count), 32'd1);

        // Short preamble: rejected at MIN 2, accepted at MIN 1
        add_pre(1); add_b(1, 8'hD5, 0); add_b(1, 8'h44, 0); add_b(1, 8'h45, 0);
        run_seg("short_pre");
        chk("short_pre:bad_const", 32'(bad_pre_count), 32'd1);
        chk("short_pre:min1_sfd_const", 32'(sfd_count1), 32'd2);

        // Corrupt preamble followed by a good frame
        add_b(1, 8'h55, 0); add_b(1, 8'h55, 0); add_b(1, 8'h5D, 0);
        add_b(1, 8'hD5, 0); add_b(1, 8'hAA, 0);
        add_gap(1);
        add_pre(3); add_b(1, 8'hD5, 0); add_b(1, 8'h66, 0); add_b(1, 8'h77, 0);
        run_seg("corrupt_pre");

        // Error on the 2nd payload byte, then a clean frame
        add_pre(7); add_b(1, 8'hD5, 0);
        add_b(1, 8'h01, 0); add_b(1, 8'h02, 1); add_b(1, 8'h03, 0); add_b(1, 8'h04, 0);
        add_gap(2);
        add_pre(7); add_b(1, 8'hD5, 0); add_b(1, 8'h05, 0); add_b(1, 8'h06, 0);
        run_seg("err_frame");

        // One-byte payload, zero payload, back-to-back with a 1-cycle gap
        add_pre(4); add_b(1, 8'hD5, 0); add_b(1, 8'hC3, 0);
        add_gap(1);
        add_pre(2); add_b(1, 8'hD5, 0);
        add_gap(1);
        add_pre(5); add_b(1, 8'hD5, 0); add_b(1, 8'h9A, 0);
        run_seg("edge_b2b");

        // False carrier in idle, long preamble beyond saturation, all-preamble burst
        add_b(0, 8'h0E, 1); add_b(0, 8'h0E, 1);
        add_pre(20); add_b(1, 8'hD5, 0); add_b(1, 8'h5A, 0);
        add_gap(1);
        add_pre(6);
        run_seg("carrier_longpre");

        // Randomized traffic
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 9);
            npre = (kind == 0) ? $urandom_range(16, 22) : $urandom_range(0, 8);
            for (int k = 0; k < npre; k++) begin
                if ($urandom_range(0, 15) == 0) add_b(1, 8'($urandom_range(0, 255)), 0);
                else add_b(1, 8'h55, 1'($urandom_range(0, 1)));
            end
            if (kind != 1) begin
                if (kind == 2) add_b(1, 8'($urandom_range(0, 255)), 0);
                else add_b(1, 8'hD5, 0);
                npay = $urandom_range(0, 8);
                for (int k = 0; k < npay; k++)
                    add_b(1, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
            end
            add_gap(1);
            for (int k = $urandom_range(0, 2); k > 0; k--)
                add_b(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        run_seg("random");

        // Reset in the middle of a frame
        add_pre(7); add_b(1, 8'hD5, 0);
        for (int k = 0; k < 5; k++) add_b(1, 8'(8'hA0 + k), 0);
        for (int c = 0; c <= 10; c++) begin
            rxd_rise = q_by[c][3:0]; rxd_fall = q_by[c][7:4];
            rx_dv = q_dv[c]; rx_er_x = q_dv[c];
            @(posedge rx_clk);
            #1;
        end
        chk("midrst:valid_before", 32'(rx_valid), 32'd1);
        chk("midrst:data_before", 32'(rx_data), 32'hA0);
        chk("midrst:sof_before", 32'(rx_sof), 32'd1);
        rxd_rise = q_by[11][3:0]; rxd_fall = q_by[11][7:4];
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst_now");
        rx_dv = 1'b0; rx_er_x = 1'b0;
        repeat (2) @(posedge rx_clk);
        #1;
        rst_n = 1'b1;
        m_sfd = 16'd0; m_bad = 16'd0; m_sfd1 = 16'd0; m_bad1 = 16'd0;
        q_dv.delete(); q_by.delete(); q_er.delete();
        for (int c = 0; c < 5; c++) begin
            @(posedge rx_clk);
            #1;
            chk("midrst_after:valid_eof", 32'({rx_valid, rx_eof, sfd_hit}), 32'd0);
        end

        // Counter wrap / saturation using preset counter values
        force dut.sfd_count_q = 16'hFFFE;
        force dut.bad_pre_count_q = 16'hFFFE;
        #1;
        release dut.sfd_count_q;
        release dut.bad_pre_count_q;
        m_sfd = 16'hFFFE; m_bad = 16'hFFFE;
        for (int f = 0; f < 3; f++) begin
            add_pre(3); add_b(1, 8'hD5, 0); add_b(1, 8'(f), 0);
            add_gap(1);
            add_b(1, 8'h12, 0);
            add_gap(1);
        end
        run_seg("wrap_sat");
        chk("wrap_sat:sfd_const", 32'(sfd_count), 32'd1);
        chk("wrap_sat:bad_const", 32'(bad_pre_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rgmii_sfd_detector.md
Name: rgmii_sfd_detector

Overview:
- Byte-level Ethernet receive front end in the rx_clk (phy1_rgmii_rx_clk) domain.
- Takes the de-DDR'd RGMII nibble pairs and locates the preamble and SFD.
- Emits a single-cycle sfd_hit pulse, which drives the LED activity display's sfd_hit_rx input, plus a framed payload byte stream with SOF/EOF/error markers and simple statistics counters.

Parameters:
- MIN_PREAMBLE, 2: minimum count of consecutive 0x55 bytes that must precede 0xD5 for the SFD to be accepted.
- MAX_PREAMBLE, 15: saturation value of the internal preamble counter. Longer preambles are still accepted.

Ports:
- rx_clk  input  1  RGMII receive clock; every flop in this block is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd_rise  input  4  IDDR rising-edge nibble; this is byte bits [3:0].
- rxd_fall  input  4  IDDR falling-edge nibble; this is byte bits [7:4].
- rx_dv  input  1  RX_CTL rising sample (data valid).
- rx_er_x  input  1  RX_CTL falling sample. The error indication is rx_dv XOR rx_er_x.
- sfd_hit  output  1  one-cycle pulse when a valid SFD is accepted.
- rx_data  output  8  payload byte, valid only when rx_valid=1.
- rx_valid  output  1  payload byte strobe.
- rx_sof  output  1  qualifies the first payload byte after the SFD.
- rx_eof  output  1  qualifies the last payload byte of the frame.
- rx_err  output  1  asserted together with rx_eof if any rx_er occurred inside the frame.
- sfd_count  output  16  accepted SFDs; wraps modulo 2^16.
- bad_pre_count  output  16  rejected preambles; saturates at 0xFFFF.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, holding register empty. Reset may assert in any state; it aborts the frame immediately, and no eof is produced.
- Stage 0 input register:
  - byte_q = {rxd_fall, rxd_rise}.
  - dv_q = rx_dv.
  - er_q = rx_dv ^ rx_er_x.
- The FSM evaluates the stage-0 values and registers its outputs, so sfd_hit rises on the 2nd rx_clk edge after 0xD5 is presented at the inputs.
- FSM states are IDLE, PRE, FRAME, DROP. pre_cnt is 4 bits and saturates at MAX_PREAMBLE.
- IDLE:
  - dv_q=0: stay. This includes dv_q=0 with er_q=1 (false carrier / carrier extension), which is ignored.
  - dv_q=1 and byte_q=0x55: go to PRE, pre_cnt=1.
  - dv_q=1 and any other byte: go to DROP, pulse a bad_pre increment.
- PRE:
  - dv_q=0: go to IDLE, bad_pre increment.
  - byte_q=0x55: stay, pre_cnt saturating +1.
  - byte_q=0xD5 and pre_cnt>=MIN_PREAMBLE: go to FRAME, sfd_hit=1 for one cycle, sfd_count+1, clear the frame error flag.
  - byte_q=0xD5 with a short preamble, or any other byte: go to DROP, bad_pre increment.
- FRAME:
  - dv_q=1: the byte enters a one-deep holding register. If the register was already full, the previous byte is emitted (rx_valid=1) and rx_sof=1 only if it is the first byte of the frame.
  - er_q=1 (while in FRAME): sets the sticky frame error flag.
  - dv_q=0: if the register is full, emit the held byte with rx_eof=1 and rx_err=flag, then go to IDLE. A zero-payload frame (SFD immediately followed by dv drop) produces no rx_valid and goes to IDLE.
  - A frame with exactly one payload byte emits it with rx_sof=rx_eof=1.
- DROP: wait for dv_q=0, then go to IDLE. No payload is output and sfd_hit is not asserted.
- Pulse widths: sfd_hit, rx_valid, rx_sof, rx_eof and rx_err are each high for at most one cycle per event. rx_sof, rx_eof and rx_err are only ever high when rx_valid is high.
- Back-to-back frames: a single dv_q=0 cycle between frames is sufficient. The next frame's preamble is detected normally.
- Counter overflow: sfd_count wraps 0xFFFF -> 0x0000. bad_pre_count holds at 0xFFFF.

Test Plan:
- Standard frame: 7x0x55, 0xD5, payload 0x11,0x22,0x33, then dv=0 -> sfd_hit once, 2 edges after D5; rx_data 0x11 (sof), 0x22, 0x33 (eof), rx_err=0; sfd_count=1.
- Short preamble: 1x0x55, 0xD5, payload -> no sfd_hit, no rx_valid, bad_pre_count=1. Repeat with MIN_PREAMBLE=1 -> sfd_hit accepted.
- Corrupt preamble: 0x55,0x55,0x5D,0xD5, 0xAA -> DROP; no sfd_hit; bad_pre_count+1. The next valid frame is accepted.
- Error mid-frame: 0xD5 after 7x0x55, 4 payload bytes, rx_er_x toggled on byte 2 -> 4 rx_valid, rx_eof with rx_err=1. The following clean frame has rx_err=0.
- Edge cases:
  - 1-byte payload -> single strobe with sof=eof=1.
  - Zero payload -> sfd_hit only.
  - Reset asserted mid-FRAME -> all outputs 0 at once and no eof.
- Counters and spacing: 65537 valid frames (forced-counter shortcut allowed) -> sfd_count wraps to 1. Back-to-back frames with a 1-cycle dv gap -> two sfd_hit pulses.
